dmi_arbiter: RTL and testbench

DMI_ARBITER -- requirements
Module: dmi_arbiter

---
 rtl/dm.sv | 15 +
 rtl/dmi_arbiter.sv | 139 +++++++++++++
 tb/tb_dmi_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm.sv
// Debug module interface payload types shared by the DMI arbiter and its clients.
package dm;

   typedef struct packed {
      logic [6:0]  addr;
      logic [31:0] data;
      logic [1:0]  op;
   } dmi_req_t;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } dmi_resp_t;

endpackage

// File: rtl/dmi_arbiter.sv
// Two-master DMI arbiter: JTAG DTM (master 0) and host bridge (master 1) share one
// debug module port with a single outstanding transaction and a response timeout.
module dmi_arbiter
   import dm::*;
#(
   parameter int unsigned TimeoutCycles = 1024
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  dmi_req_t  [1:0] m_req_i,
   input  logic      [1:0] m_req_valid_i,
   output logic      [1:0] m_req_ready_o,
   output dmi_resp_t       m_resp_o,
   output logic      [1:0] m_resp_valid_o,
   input  logic      [1:0] m_resp_ready_i,
   output dmi_req_t        dmi_req_o,
   output logic            dmi_req_valid_o,
   input  logic            dmi_req_ready_i,
   input  dmi_resp_t       dmi_resp_i,
   input  logic            dmi_resp_valid_i,
   output logic            dmi_resp_ready_o,
   output logic            busy_o,
   output logic            timeout_o
);

   localparam int unsigned TimerW    = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
   localparam bit          TimeoutEn = (TimeoutCycles != 0);
   localparam logic [TimerW-1:0] TimerMax =
      TimeoutEn ? TimerW'(TimeoutCycles - 1) : {TimerW{1'b1}};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      WAIT    = 2'd2,
      DELIVER = 2'd3
   } state_e;

   state_e            state_q, state_d;
   dmi_req_t          req_q, req_d;
   dmi_resp_t         resp_q, resp_d;
   logic              grant_q, grant_d;
   logic              last_grant_q, last_grant_d;
   logic              drop_pending_q, drop_pending_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic              grant_c;
   logic              resp_acc_c;

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= IDLE;
         req_q          <= '0;
         resp_q         <= '0;
         grant_q        <= 1'b0;
         last_grant_q   <= 1'b1;
         drop_pending_q <= 1'b0;
         timer_q        <= '0;
      end else begin
         state_q        <= state_d;
         req_q          <= req_d;
         resp_q         <= resp_d;
         grant_q        <= grant_d;
         last_grant_q   <= last_grant_d;
         drop_pending_q <= drop_pending_d;
         timer_q        <= timer_d;
      end
   end

   // Next-state, arbitration, timeout and handshake outputs.
   always_comb begin
      state_d          = state_q;
      req_d            = req_q;
      resp_d           = resp_q;
      grant_d          = grant_q;
      last_grant_d     = last_grant_q;
      drop_pending_d   = drop_pending_q;
      timer_d          = timer_q;
      grant_c          = 1'b0;
      m_req_ready_o    = 2'b00;
      m_resp_valid_o   = 2'b00;
      dmi_req_valid_o  = 1'b0;
      timeout_o        = 1'b0;
      dmi_req_o        = req_q;
      m_resp_o         = resp_q;
      busy_o           = (state_q != IDLE);
      dmi_resp_ready_o = (state_q != DELIVER);
      resp_acc_c       = dmi_resp_valid_i && dmi_resp_ready_o;

      // A response owed to a timed-out request is swallowed wherever it lands.
      if (resp_acc_c && drop_pending_q) begin
         drop_pending_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (!rst_i && (m_req_valid_i != 2'b00)) begin
               grant_c       = (m_req_valid_i == 2'b11) ? ~last_grant_q : m_req_valid_i[1];
               m_req_ready_o = grant_c ? 2'b10 : 2'b01;
               req_d         = m_req_i[grant_c];
               grant_d       = grant_c;
               state_d       = REQ;
            end
         end
         REQ: begin
            dmi_req_valid_o = 1'b1;
            if (dmi_req_ready_i) begin
               timer_d = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (resp_acc_c && drop_pending_q) begin
               timer_d = timer_q;
            end else if (resp_acc_c) begin
               resp_d  = dmi_resp_i;
               state_d = DELIVER;
            end else if (TimeoutEn && (timer_q == TimerMax)) begin
               resp_d         = '{data: 32'h0, resp: 2'h2};
               drop_pending_d = 1'b1;
               timeout_o      = 1'b1;
               state_d        = DELIVER;
            end else if (timer_q != TimerMax) begin
               timer_d = timer_q + TimerW'(1);
            end
         end
         DELIVER: begin
            m_resp_valid_o = grant_q ? 2'b10 : 2'b01;
            if (m_resp_ready_i[grant_q]) begin
               last_grant_d = grant_q;
               state_d      = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_dmi_arbiter.sv
// Self-checking bench for dmi_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_dmi_arbiter;

   localparam int TO = 8;

   logic                 clk_i = 1'b0;
   logic                 rst_i;
   dm::dmi_req_t  [1:0]  m_req_i;
   logic          [1:0]  m_req_valid_i;
   logic          [1:0]  m_req_ready_o;
   dm::dmi_resp_t        m_resp_o;
   logic          [1:0]  m_resp_valid_o;
   logic          [1:0]  m_resp_ready_i;
   dm::dmi_req_t         dmi_req_o;
   logic                 dmi_req_valid_o;
   logic                 dmi_req_ready_i;
   dm::dmi_resp_t        dmi_resp_i;
   logic                 dmi_resp_valid_i;
   logic                 dmi_resp_ready_o;
   logic                 busy_o;
   logic                 timeout_o;

   dmi_arbiter #(.TimeoutCycles(TO)) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .m_req_i          (m_req_i),
      .m_req_valid_i    (m_req_valid_i),
      .m_req_ready_o    (m_req_ready_o),
      .m_resp_o         (m_resp_o),
      .m_resp_valid_o   (m_resp_valid_o),
      .m_resp_ready_i   (m_resp_ready_i),
      .dmi_req_o        (dmi_req_o),
      .dmi_req_valid_o  (dmi_req_valid_o),
      .dmi_req_ready_i  (dmi_req_ready_i),
      .dmi_resp_i       (dmi_resp_i),
      .dmi_resp_valid_i (dmi_resp_valid_i),
      .dmi_resp_ready_o (dmi_resp_ready_o),
      .busy_o           (busy_o),
      .timeout_o        (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- transaction-level reference model ----------------
   bit            mdl_busy = 1'b0;   // a transaction is owned by the arbiter
   bit            mdl_sent = 1'b0;   // its request reached the DM
   bit            mdl_has  = 1'b0;   // a response is ready for the master
   bit            mdl_drop = 1'b0;   // a timed-out response is still owed by the DM
   int            mdl_master = 0;
   int            mdl_last   = 1;
   int            mdl_wait   = 0;
   dm::dmi_req_t  mdl_req  = '0;
   dm::dmi_resp_t mdl_resp = '0;

   logic [1:0] e_rdy, e_mv, v;
   logic       e_busy, e_dv, e_rr, e_to, acc, waiting, deliv;
   int         pick;

   always @(negedge clk_i) begin
      v       = m_req_valid_i;
      pick    = (v == 2'b11) ? (1 - mdl_last) : (v[1] ? 1 : 0);
      e_busy  = mdl_busy;
      e_dv    = mdl_busy && !mdl_sent;
      deliv   = mdl_busy && mdl_has;
      waiting = mdl_busy && mdl_sent && !mdl_has;
      e_rr    = !deliv;
      e_rdy   = (!mdl_busy && !rst_i && v != 2'b00) ? ((pick == 1) ? 2'b10 : 2'b01) : 2'b00;
      e_mv    = deliv ? ((mdl_master == 1) ? 2'b10 : 2'b01) : 2'b00;
      acc     = dmi_resp_valid_i && e_rr;
      e_to    = waiting && !acc && (mdl_wait == TO - 1);

      chk("busy", 64'(busy_o), 64'(e_busy));
      chk("m_req_ready", 64'(m_req_ready_o), 64'(e_rdy));
      chk("dmi_req_valid", 64'(dmi_req_valid_o), 64'(e_dv));
      chk("dmi_resp_ready", 64'(dmi_resp_ready_o), 64'(e_rr));
      chk("m_resp_valid", 64'(m_resp_valid_o), 64'(e_mv));
      chk("timeout", 64'(timeout_o), 64'(e_to));
      if (e_dv) chk("dmi_req", 64'(dmi_req_o), 64'(mdl_req));
      if (deliv) chk("m_resp", 64'(m_resp_o), 64'(mdl_resp));

      if (rst_i) begin
         mdl_busy = 1'b0; mdl_sent = 1'b0; mdl_has = 1'b0; mdl_drop = 1'b0; mdl_last = 1;
      end else begin
         if (acc) begin
            if (mdl_drop) mdl_drop = 1'b0;
            else if (waiting) begin mdl_has = 1'b1; mdl_resp = dmi_resp_i; end
         end else if (e_to) begin
            mdl_has = 1'b1; mdl_resp = '{data: 32'h0, resp: 2'h2}; mdl_drop = 1'b1;
         end else if (waiting) begin
            mdl_wait++;
         end
         if (!mdl_busy) begin
            if (v != 2'b00) begin
               mdl_busy = 1'b1; mdl_master = pick; mdl_req = m_req_i[pick];
               mdl_sent = 1'b0; mdl_has = 1'b0;
            end
         end else if (!mdl_sent) begin
            if (dmi_req_ready_i) begin mdl_sent = 1'b1; mdl_wait = 0; end
         end else if (deliv && m_resp_ready_i[mdl_master]) begin
            mdl_last = mdl_master; mdl_busy = 1'b0; mdl_has = 1'b0;
         end
      end
   end

   // ---------------- stimulus agents ----------------
   dm::dmi_req_t  mq0[$], mq1[$];
   dm::dmi_resp_t rq[$];
   int            dq[$];
   int            grant_log[$];

   function automatic dm::dmi_req_t rand_req();
      dm::dmi_req_t r;
      r.addr = 7'($urandom);
      r.data = $urandom;
      r.op   = 2'($urandom_range(0, 2));
      return r;
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // One cycle of master/DM agent behaviour; entered and left just after a rising edge.
   task automatic auto_step(input bit rnd);
      bit p0, p1;
      dm::dmi_resp_t r;
      p0 = 1'b0; p1 = 1'b0;
      if (rnd) begin
         rst_i = ($urandom_range(0, 199) == 0);
         if (mq0.size() < 2 && $urandom_range(0, 3) == 0) mq0.push_back(rand_req());
         if (mq1.size() < 2 && $urandom_range(0, 3) == 0) mq1.push_back(rand_req());
         m_resp_ready_i  = 2'($urandom_range(0, 3));
         dmi_req_ready_i = ($urandom_range(0, 2) != 0);
      end else begin
         rst_i = 1'b0; m_resp_ready_i = 2'b11; dmi_req_ready_i = 1'b1;
      end
      if (dq.size() > 0 && dq[0] > 0) dq[0] = dq[0] - 1;
      m_req_valid_i    = {mq1.size() != 0, mq0.size() != 0};
      m_req_i[0]       = (mq0.size() != 0) ? mq0[0] : '0;
      m_req_i[1]       = (mq1.size() != 0) ? mq1[0] : '0;
      dmi_resp_valid_i = (dq.size() > 0) && (dq[0] == 0);
      dmi_resp_i       = (rq.size() != 0) ? rq[0] : '0;
      @(negedge clk_i);
      if (m_req_valid_i[0] && m_req_ready_o[0]) begin p0 = 1'b1; grant_log.push_back(0); end
      if (m_req_valid_i[1] && m_req_ready_o[1]) begin p1 = 1'b1; grant_log.push_back(1); end
      if (dmi_resp_valid_i && dmi_resp_ready_o) begin void'(dq.pop_front()); void'(rq.pop_front()); end
      if (dmi_req_valid_o && dmi_req_ready_i) begin
         r.data = rnd ? $urandom : 32'h0E0E_0000 + 32'(dq.size());
         r.resp = rnd ? 2'($urandom_range(0, 3)) : 2'h0;
         dq.push_back(rnd ? $urandom_range(0, 12) : 1);
         rq.push_back(r);
      end
      tick();
      if (p0) void'(mq0.pop_front());
      if (p1) void'(mq1.pop_front());
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_m_req_ready"}, 64'(m_req_ready_o), 64'(2'b00));
      chk({tag, "_m_resp_valid"}, 64'(m_resp_valid_o), 64'(2'b00));
      chk({tag, "_dmi_req_valid"}, 64'(dmi_req_valid_o), 64'(1'b0));
      chk({tag, "_busy"}, 64'(busy_o), 64'(1'b0));
      chk({tag, "_timeout"}, 64'(timeout_o), 64'(1'b0));
      chk({tag, "_dmi_resp_ready"}, 64'(dmi_resp_ready_o), 64'(1'b1));
   endtask

   dm::dmi_req_t  req_a0, req_a1;
   dm::dmi_resp_t exp_r;

   initial begin
      rst_i = 1'b1; m_req_valid_i = 2'b00; m_req_i = '0; m_resp_ready_i = 2'b00;
      dmi_req_ready_i = 1'b0; dmi_resp_i = '0; dmi_resp_valid_i = 1'b0;

      // Both masters valid through reset: m0 read 0x11, then m1 write 0x04.
      req_a0 = '{addr: 7'h11, data: 32'h0, op: 2'd1};
      req_a1 = '{addr: 7'h04, data: 32'hDEADBEEF, op: 2'd2};
      m_req_i[0] = req_a0; m_req_i[1] = req_a1; m_req_valid_i = 2'b11;
      dmi_req_ready_i = 1'b1; m_resp_ready_i = 2'b11;
      tick(); tick();
      @(negedge clk_i); chk_reset_outs("rst");
      tick(); rst_i = 1'b0;                                   // cycle 0
      @(negedge clk_i); chk("grant_m0_first", 64'(m_req_ready_o), 64'(2'b01));
      tick(); m_req_valid_i = 2'b10;                          // cycle 1
      @(negedge clk_i); chk("c1_req_valid", 64'(dmi_req_valid_o), 64'(1'b1));
      chk("c1_dmi_req_m0", 64'(dmi_req_o), 64'(req_a0));
      tick();                                                 // cycle 2
      @(negedge clk_i); chk("c2_req_valid_low", 64'(dmi_req_valid_o), 64'(1'b0));
      tick(); dmi_resp_valid_i = 1'b1; dmi_resp_i = '{data: 32'h12345678, resp: 2'h0};
      @(negedge clk_i); chk("c3_no_resp_yet", 64'(m_resp_valid_o), 64'(2'b00));
      tick(); dmi_resp_valid_i = 1'b0;                        // cycle 4
      @(negedge clk_i); chk("c4_resp_valid_m0", 64'(m_resp_valid_o), 64'(2'b01));
      exp_r = '{data: 32'h12345678, resp: 2'h0};
      chk("c4_resp_data", 64'(m_resp_o), 64'(exp_r));
      tick();
      @(negedge clk_i); chk("grant_m1_second", 64'(m_req_ready_o), 64'(2'b10));
      tick(); m_req_valid_i = 2'b00;
      @(negedge clk_i); chk("dmi_req_m1", 64'(dmi_req_o), 64'(req_a1));
      tick(); dmi_resp_valid_i = 1'b1; dmi_resp_i = '{data: 32'hA5A5A5A5, resp: 2'h0};
      tick(); dmi_resp_valid_i = 1'b0;
      @(negedge clk_i); chk("resp_valid_m1", 64'(m_resp_valid_o), 64'(2'b10));

      // Master 0 stalls its response for five cycles while master 1 waits.
      tick(); m_resp_ready_i = 2'b00;
      m_req_i[0] = '{addr: 7'h20, data: 32'h0, op: 2'd1}; m_req_valid_i = 2'b01;
      tick(); m_req_valid_i = 2'b10; m_req_i[1] = '{addr: 7'h21, data: 32'h1, op: 2'd2};
      tick(); dmi_resp_valid_i = 1'b1; dmi_resp_i = '{data: 32'hCAFEF00D, resp: 2'h0};
      tick(); dmi_resp_valid_i = 1'b0;
      exp_r = '{data: 32'hCAFEF00D, resp: 2'h0};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         chk("stall_resp_stable", 64'(m_resp_o), 64'(exp_r));
         chk("stall_resp_valid", 64'(m_resp_valid_o), 64'(2'b01));
         chk("stall_dm_ready_low", 64'(dmi_resp_ready_o), 64'(1'b0));
         chk("stall_no_grant", 64'(m_req_ready_o), 64'(2'b00));
         tick();
      end
      m_resp_ready_i = 2'b11;
      tick();
      @(negedge clk_i); chk("grant_m1_after_stall", 64'(m_req_ready_o), 64'(2'b10));
      tick(); m_req_valid_i = 2'b00;
      tick(); dmi_resp_valid_i = 1'b1; dmi_resp_i = '{data: 32'h11111111, resp: 2'h0};
      tick(); dmi_resp_valid_i = 1'b0;

      // Silent DM: timeout after eight WAIT cycles, late response dropped.
      tick(); m_req_i[0] = '{addr: 7'h30, data: 32'h0, op: 2'd1}; m_req_valid_i = 2'b01;
      tick(); m_req_valid_i = 2'b00;
      tick();
      for (int k = 0; k < TO; k++) begin
         @(negedge clk_i); chk("timeout_pulse", 64'(timeout_o), 64'(k == TO - 1));
         tick();
      end
      exp_r = '{data: 32'h0, resp: 2'h2};
      @(negedge clk_i); chk("timeout_resp", 64'(m_resp_o), 64'(exp_r));
      chk("timeout_resp_valid", 64'(m_resp_valid_o), 64'(2'b01));
      tick(); dmi_resp_valid_i = 1'b1; dmi_resp_i = '{data: 32'h00000BAD, resp: 2'h0};
      tick(); dmi_resp_valid_i = 1'b0;
      m_req_i[1] = '{addr: 7'h31, data: 32'h0, op: 2'd1}; m_req_valid_i = 2'b10;
      tick(); m_req_valid_i = 2'b00;
      tick(); dmi_resp_valid_i = 1'b1; dmi_resp_i = '{data: 32'h600DF00D, resp: 2'h0};
      tick(); dmi_resp_valid_i = 1'b0;
      exp_r = '{data: 32'h600DF00D, resp: 2'h0};
      @(negedge clk_i); chk("post_timeout_resp", 64'(m_resp_o), 64'(exp_r));
      chk("post_timeout_valid", 64'(m_resp_valid_o), 64'(2'b10));

      // Reset while waiting, then a late DM response.
      tick(); m_req_i[0] = '{addr: 7'h40, data: 32'h0, op: 2'd1}; m_req_valid_i = 2'b01;
      tick(); m_req_valid_i = 2'b00;
      tick();
      tick(); rst_i = 1'b1;
      tick(); dmi_resp_valid_i = 1'b1; dmi_resp_i = '{data: 32'h0000BEEF, resp: 2'h0};
      @(negedge clk_i); chk_reset_outs("midrst");
      tick(); rst_i = 1'b0;
      tick(); dmi_resp_valid_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         chk("late_resp_dropped", 64'(m_resp_valid_o), 64'(2'b00));
         chk("late_resp_idle", 64'(busy_o), 64'(1'b0));
         tick();
      end

      // m0 with two queued requests against m1 holding valid: m0, m1, m0.
      grant_log.delete();
      mq0.push_back(rand_req()); mq0.push_back(rand_req()); mq1.push_back(rand_req());
      for (int i = 0; i < 60 && grant_log.size() < 3; i++) auto_step(1'b0);
      chk("fair_order_len", 64'(grant_log.size()), 64'(3));
      for (int i = 0; i < 3; i++) begin
         if (i < grant_log.size()) chk("fair_order", 64'(grant_log[i]), 64'((i == 1) ? 1 : 0));
      end
      for (int i = 0; i < 20; i++) auto_step(1'b0);

      // Randomized traffic with stalls, timeouts, late responses and resets.
      for (int i = 0; i < 3000; i++) auto_step(1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got running expected finished");
      $fatal(1, "watchdog");
   end

endmodule
